// File: rtl/uart_rx_frontend_if.sv
// Byte handshake between the UART receive front end and the packet parser.
//   rx_data  : byte presented to the parser, valid in the rx_valid cycle
//   rx_valid : 1-cycle pulse, a new byte is on rx_data
//   rx_ready : parser ready; while low no new rx_valid pulse is issued
// master = byte source (front end), slave = byte sink (parser).
interface uart_rx_frontend_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front end: synchronises uart_rxd, deserialises frames, buffers
// bytes in a FIFO and hands them to the parser over a pulsed byte handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   uart_rxd     : raw serial input, idle high, asynchronous to clk
//   rx_if        : master side of rx_data/rx_valid/rx_ready
//   fifo_level   : bytes currently buffered
//   frame_err    : 1-cycle pulse, stop bit sampled low
//   overrun_err  : 1-cycle pulse, byte dropped because the FIFO was full
module uart_rx_frontend #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              uart_rxd,
   uart_rx_frontend_if.master                rx_if,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              frame_err,
   output logic                              overrun_err
);

   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam int unsigned LW       = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CNT_LAST = CLKS_PER_BIT - 1;
   localparam int unsigned CNT_HALF = CLKS_PER_BIT / 2 - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_e;

   logic             sync1_q, sync2_q;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [7:0]       shift_q;
   logic             frame_err_q;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [LW-1:0]    level_q, level_d;
   logic [7:0]       rx_data_q;
   logic             rx_valid_q;
   logic             overrun_err_q;

   logic             cnt_last_c, push_c, pop_c, full_c, wr_en_c;

   // Two-flop synchroniser; resets to the idle line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= uart_rxd;
         sync2_q <= sync1_q;
      end
   end

   assign cnt_last_c = (cnt_q == CNT_W'(CNT_LAST));
   // A good stop sample pushes the assembled byte in the same cycle.
   assign push_c     = (state_q == S_STOP) && cnt_last_c && sync2_q;
   assign full_c     = (level_q == LW'(FIFO_DEPTH));
   // Pop only after an idle rx_valid cycle, so pulses are always separated.
   assign pop_c      = (level_q != '0) && rx_if.rx_ready && !rx_valid_q;
   // When full, a simultaneous pop frees the slot for the incoming byte.
   assign wr_en_c    = push_c && (!full_c || pop_c);

   // Frame deserialiser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!sync2_q) begin
                  state_q <= S_START;
                  cnt_q   <= '0;
               end
            end
            S_START: begin
               // Mid start bit: a high line here means the falling edge was a glitch.
               if (cnt_q == CNT_W'(CNT_HALF)) begin
                  cnt_q <= '0;
                  idx_q <= '0;
                  state_q <= sync2_q ? S_IDLE : S_DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (cnt_last_c) begin
                  cnt_q          <= '0;
                  shift_q[idx_q] <= sync2_q;
                  idx_q          <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_STOP: begin
               // Leave at mid stop bit so the next start edge is caught early.
               if (cnt_last_c) begin
                  cnt_q <= '0;
                  if (sync2_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_WAIT_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_WAIT_IDLE: begin
               if (sync2_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // FIFO storage is not reset; the pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en_c) mem[wptr_q] <= shift_q;
   end

   always_comb begin
      level_d = level_q;
      if (wr_en_c && !pop_c)      level_d = level_q + LW'(1);
      else if (!wr_en_c && pop_c) level_d = level_q - LW'(1);
   end

   // FIFO pointers, level and registered output handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q        <= '0;
         rptr_q        <= '0;
         level_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         level_q       <= level_d;
         rx_valid_q    <= pop_c;
         overrun_err_q <= push_c && !wr_en_c;
         if (wr_en_c) wptr_q <= wptr_q + AW'(1);
         if (pop_c) begin
            rptr_q    <= rptr_q + AW'(1);
            rx_data_q <= mem[rptr_q];
         end
      end
   end

   assign rx_if.rx_data  = rx_data_q;
   assign rx_if.rx_valid = rx_valid_q;
   assign fifo_level     = level_q;
   assign frame_err      = frame_err_q;
   assign overrun_err    = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend at CLKS_PER_BIT=8, FIFO_DEPTH=16.
// The stimulus process queues expected bytes; the monitor pops and compares on rx_valid.
module tb_uart_rx_frontend;
   localparam int unsigned CPB   = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          uart_rxd;
   logic [LW-1:0] fifo_level;
   logic          frame_err;
   logic          overrun_err;

   uart_rx_frontend_if rx_if ();

   uart_rx_frontend #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .uart_rxd    (uart_rxd),
      .rx_if       (rx_if),
      .fifo_level  (fifo_level),
      .frame_err   (frame_err),
      .overrun_err (overrun_err)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  exp_q [$];
   int          frame_cnt = 0;
   int          ovr_cnt   = 0;
   int          vpulse    = 0;
   int          cycle     = 0;
   int          last_valid_cycle = 0;
   logic        prev_valid = 1'b0;
   logic        rdy_prev;

   always @(posedge clk) cycle <= cycle + 1;

   // Monitor: compare each delivered byte with the scoreboard head.
   always begin
      logic [7:0] e;
      @(posedge clk);
      rdy_prev = rx_if.rx_ready;
      #1;
      if (rx_if.rx_valid) begin
         vpulse++;
         last_valid_cycle = cycle;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rx_data_unexpected actual=%02h required=none", rx_if.rx_data);
         end else begin
            e = exp_q.pop_front();
            if (rx_if.rx_data !== e) begin
               bad++;
               $display("FAIL rx_data actual=%02h required=%02h", rx_if.rx_data, e);
            end
         end
         total++;
         if (!rdy_prev || prev_valid) begin
            bad++;
            $display("FAIL rx_valid_rule actual=ready_prev:%0b valid_prev:%0b required=1,0",
                     rdy_prev, prev_valid);
         end
      end
      if (frame_err)   frame_cnt++;
      if (overrun_err) ovr_cnt++;
      prev_valid = rx_if.rx_valid;
   end

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      @(negedge clk);
      uart_rxd = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = d[i];
         idle(CPB);
      end
      uart_rxd = stop;
      idle(CPB);
      uart_rxd = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
      check(name, exp_q.size(), 0);
      idle(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, f0, o0, c0, lat;
      uart_rxd = 1'b1;
      rx_if.rx_ready = 1'b0;
      rst_n = 1'b0;
      idle(5);
      check("reset_rx_valid", int'(rx_if.rx_valid), 0);
      check("reset_rx_data", int'(rx_if.rx_data), 0);
      check("reset_fifo_level", int'(fifo_level), 0);
      check("reset_frame_err", int'(frame_err), 0);
      check("reset_overrun_err", int'(overrun_err), 0);
      rst_n = 1'b1;
      idle(CPB);

      // Single frame with the parser ready.
      rx_if.rx_ready = 1'b1;
      exp_q.push_back(8'hA5);
      c0 = cycle;
      send_frame(8'hA5, 1'b1);
      drain("a5_drain");
      lat = last_valid_cycle - c0;
      check("a5_latency_in_range", int'(lat >= int'(9 * CPB) && lat <= int'(11 * CPB)), 1);
      check("a5_frame_err", frame_cnt, 0);
      check("a5_overrun_err", ovr_cnt, 0);

      // Bytes buffered while the parser is not ready.
      rx_if.rx_ready = 1'b0;
      v0 = vpulse;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      idle(2 * CPB);
      check("held_level", int'(fifo_level), 3);
      check("held_no_valid", vpulse - v0, 0);
      rx_if.rx_ready = 1'b1;
      drain("held_drain");
      check("held_pulses", vpulse - v0, 3);
      check("held_level_after", int'(fifo_level), 0);

      // Overrun: 17 bytes into a 16-entry FIFO.
      rx_if.rx_ready = 1'b0;
      o0 = ovr_cnt;
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(8'(i));
         send_frame(8'(i), 1'b1);
      end
      idle(2);
      check("ovr_before_17th", ovr_cnt - o0, 0);
      check("ovr_level_full", int'(fifo_level), 16);
      send_frame(8'h10, 1'b1);
      idle(2 * CPB);
      check("ovr_pulse_once", ovr_cnt - o0, 1);
      check("ovr_level_kept", int'(fifo_level), 16);
      rx_if.rx_ready = 1'b1;
      drain("ovr_drain");
      check("ovr_level_after", int'(fifo_level), 0);

      // Framing error followed by a break, then a good frame.
      f0 = frame_cnt;
      v0 = vpulse;
      send_frame(8'h81, 1'b0);
      uart_rxd = 1'b0;
      idle(3 * CPB);
      uart_rxd = 1'b1;
      idle(2 * CPB);
      check("ferr_once", frame_cnt - f0, 1);
      check("ferr_no_push", int'(fifo_level), 0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      drain("ferr_drain");
      check("ferr_still_once", frame_cnt - f0, 1);
      check("ferr_pulses", vpulse - v0, 1);

      // Short low glitch on an idle line.
      v0 = vpulse; f0 = frame_cnt; o0 = ovr_cnt;
      uart_rxd = 1'b0;
      idle(CPB / 4);
      uart_rxd = 1'b1;
      idle(4 * CPB);
      check("glitch_valid", vpulse - v0, 0);
      check("glitch_frame_err", frame_cnt - f0, 0);
      check("glitch_overrun", ovr_cnt - o0, 0);
      check("glitch_level", int'(fifo_level), 0);

      // Reset mid-frame with two bytes buffered.
      rx_if.rx_ready = 1'b0;
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      idle(2);
      check("rst_level_before", int'(fifo_level), 2);
      uart_rxd = 1'b0;
      idle(CPB);
      uart_rxd = 1'b1;
      idle(2 * CPB);
      rst_n = 1'b0;
      idle(2);
      check("rst_rx_valid", int'(rx_if.rx_valid), 0);
      check("rst_rx_data", int'(rx_if.rx_data), 0);
      check("rst_fifo_level", int'(fifo_level), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_overrun_err", int'(overrun_err), 0);
      rst_n = 1'b1;
      rx_if.rx_ready = 1'b1;
      idle(CPB);
      v0 = vpulse;
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      drain("rst_drain");
      check("rst_one_pulse", vpulse - v0, 1);
      check("rst_level_after", int'(fifo_level), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
